// File: rtl/ps2_direction_decoder_pkg.sv
// Shared constants for the PS/2 direction decoder: set-2 scan codes,
// key-flag indices, receive FSM encodings and the scan-code lookup.
package ps2_direction_decoder_pkg;

    // Set-2 make codes (break = F0 prefix, extended = E0 prefix)
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Bit positions of the held-key flags inside the flag vector
    localparam int NUM_KEYS   = 10;
    localparam int K_P1_UP    = 0;
    localparam int K_P1_DOWN  = 1;
    localparam int K_P1_LEFT  = 2;
    localparam int K_P1_RIGHT = 3;
    localparam int K_P1_FIRE  = 4;
    localparam int K_P2_UP    = 5;
    localparam int K_P2_DOWN  = 6;
    localparam int K_P2_LEFT  = 7;
    localparam int K_P2_RIGHT = 8;
    localparam int K_P2_FIRE  = 9;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // One-hot flag selection for a (prefix, code) pair; zero when unmapped.
    // Arrow codes only match with the E0 prefix, everything else only without.
    function automatic logic [NUM_KEYS-1:0] key_match(input logic ext, input logic [7:0] code);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        if (!ext) begin
            case (code)
                SC_W:     m[K_P1_UP]    = 1'b1;
                SC_S:     m[K_P1_DOWN]  = 1'b1;
                SC_A:     m[K_P1_LEFT]  = 1'b1;
                SC_D:     m[K_P1_RIGHT] = 1'b1;
                SC_SPACE: m[K_P1_FIRE]  = 1'b1;
                SC_ENTER: m[K_P2_FIRE]  = 1'b1;
                default:  m = '0;
            endcase
        end else begin
            case (code)
                SC_UP:    m[K_P2_UP]    = 1'b1;
                SC_DOWN:  m[K_P2_DOWN]  = 1'b1;
                SC_LEFT:  m[K_P2_LEFT]  = 1'b1;
                SC_RIGHT: m[K_P2_RIGHT] = 1'b1;
                default:  m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the raw pins, detects falling edges of
// the keyboard clock and deserialises start/8 data/odd parity/stop frames.
// A stalled frame is abandoned after TIMEOUT_CYCLES without a clock edge.
module ps2_rx_frame
    import ps2_direction_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic       Clock,
    input  logic       rstn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       frame_err
);

    logic            clk_sync1_reg, clk_sync2_reg, clk_prev_reg;
    logic            dat_sync1_reg, dat_sync2_reg;
    logic            fe;
    rx_state_t       state_reg, state_next;
    logic [2:0]      bitcnt_reg;
    logic [7:0]      shift_reg;
    logic            parity_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic [7:0]      scancode_reg;
    logic            valid_reg, err_reg;
    logic            timeout, shift_en, cap_par, frame_ok, frame_bad;

    // Two-flop synchronisers plus previous-clock flop; idle-high lines reset to 1
    always_ff @(posedge Clock or negedge rstn) begin
        if (!rstn) begin
            clk_sync1_reg <= 1'b1;
            clk_sync2_reg <= 1'b1;
            clk_prev_reg  <= 1'b1;
            dat_sync1_reg <= 1'b1;
            dat_sync2_reg <= 1'b1;
        end else begin
            clk_sync1_reg <= PS2_CLK;
            clk_sync2_reg <= clk_sync1_reg;
            clk_prev_reg  <= clk_sync2_reg;
            dat_sync1_reg <= PS2_DAT;
            dat_sync2_reg <= dat_sync1_reg;
        end
    end

    assign fe      = clk_prev_reg & ~clk_sync2_reg;
    assign timeout = (state_reg != RX_IDLE) && !fe && (to_cnt_reg >= TO_W'(TIMEOUT_CYCLES));

    // Receive state register
    always_ff @(posedge Clock or negedge rstn) begin
        if (!rstn) state_reg <= RX_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state and per-edge control decode
    always_comb begin
        state_next = state_reg;
        shift_en   = 1'b0;
        cap_par    = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        if (timeout) begin
            state_next = RX_IDLE;
            frame_bad  = 1'b1;
        end else if (fe) begin
            case (state_reg)
                RX_IDLE: begin
                    if (!dat_sync2_reg) state_next = RX_DATA;
                    else                frame_bad  = 1'b1;
                end
                RX_DATA: begin
                    shift_en = 1'b1;
                    if (bitcnt_reg == 3'd7) state_next = RX_PARITY;
                end
                RX_PARITY: begin
                    cap_par    = 1'b1;
                    state_next = RX_STOP;
                end
                RX_STOP: begin
                    if (dat_sync2_reg && ((^shift_reg) ^ parity_reg)) frame_ok  = 1'b1;
                    else                                              frame_bad = 1'b1;
                    state_next = RX_IDLE;
                end
                default: state_next = RX_IDLE;
            endcase
        end
    end

    // Frame datapath: bit counter, LSB-first shifter, parity, timeout counter, outputs
    always_ff @(posedge Clock or negedge rstn) begin
        if (!rstn) begin
            bitcnt_reg   <= 3'd0;
            shift_reg    <= 8'h00;
            parity_reg   <= 1'b0;
            to_cnt_reg   <= '0;
            scancode_reg <= 8'h00;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (state_reg == RX_IDLE) bitcnt_reg <= 3'd0;
            else if (shift_en)        bitcnt_reg <= bitcnt_reg + 3'd1;
            if (shift_en) shift_reg  <= {dat_sync2_reg, shift_reg[7:1]};
            if (cap_par)  parity_reg <= dat_sync2_reg;
            if (fe || state_next == RX_IDLE) to_cnt_reg <= '0;
            else                             to_cnt_reg <= to_cnt_reg + 1'b1;
            if (frame_ok) scancode_reg <= shift_reg;
            valid_reg <= frame_ok;
            err_reg   <= frame_bad;
        end
    end

    assign scancode       = scancode_reg;
    assign scancode_valid = valid_reg;
    assign frame_err      = err_reg;

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard to two-player held-key flags. Tracks E0/F0 prefixes and
// keeps one level flag per mapped key, set on make and cleared on break.
module ps2_direction_decoder
    import ps2_direction_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic       Clock,
    input  logic       rstn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p1_left,
    output logic       p1_right,
    output logic       p2_up,
    output logic       p2_down,
    output logic       p2_left,
    output logic       p2_right,
    output logic       p1_fire,
    output logic       p2_fire,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       frame_err
);

    logic [7:0]          rx_code;
    logic                rx_valid, rx_err;
    logic                ext_reg, brk_reg;
    logic                key_write;
    logic [NUM_KEYS-1:0] hit;
    logic [NUM_KEYS-1:0] flag_reg, flag_next;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_rx (
        .Clock          (Clock),
        .rstn           (rstn),
        .PS2_CLK        (PS2_CLK),
        .PS2_DAT        (PS2_DAT),
        .scancode       (rx_code),
        .scancode_valid (rx_valid),
        .frame_err      (rx_err)
    );

    // A non-prefix byte is the one that actually touches a key flag
    assign key_write = rx_valid && (rx_code != SC_EXT) && (rx_code != SC_BRK);
    assign hit       = key_match(ext_reg, rx_code);

    // Prefix tracker: E0/F0 accumulate, any other byte or a bad frame clears them
    always_ff @(posedge Clock or negedge rstn) begin
        if (!rstn) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (rx_err) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (rx_valid) begin
            if (rx_code == SC_EXT) begin
                ext_reg <= 1'b1;
            end else if (rx_code == SC_BRK) begin
                brk_reg <= 1'b1;
            end else begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end
        end
    end

    // Per-key next value: make sets, break clears, unmatched keys hold
    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_flag
            assign flag_next[gi] = (key_write && hit[gi]) ? ~brk_reg : flag_reg[gi];
        end
    endgenerate

    // Held-key flag register
    always_ff @(posedge Clock or negedge rstn) begin
        if (!rstn) flag_reg <= '0;
        else       flag_reg <= flag_next;
    end

    assign p1_up          = flag_reg[K_P1_UP];
    assign p1_down        = flag_reg[K_P1_DOWN];
    assign p1_left        = flag_reg[K_P1_LEFT];
    assign p1_right       = flag_reg[K_P1_RIGHT];
    assign p1_fire        = flag_reg[K_P1_FIRE];
    assign p2_up          = flag_reg[K_P2_UP];
    assign p2_down        = flag_reg[K_P2_DOWN];
    assign p2_left        = flag_reg[K_P2_LEFT];
    assign p2_right       = flag_reg[K_P2_RIGHT];
    assign p2_fire        = flag_reg[K_P2_FIRE];
    assign scancode       = rx_code;
    assign scancode_valid = rx_valid;
    assign frame_err      = rx_err;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder: table of PS/2 frames with the
// expected strobe counts, scancode and flag vector after each, plus hand
// sequences for timeout and asynchronous reset mid-frame.
module tb_ps2_direction_decoder;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 8;
    localparam int GAP     = 30;

    logic       Clock = 1'b0;
    logic       rstn;
    logic       PS2_CLK, PS2_DAT;
    logic       p1_up, p1_down, p1_left, p1_right;
    logic       p2_up, p2_down, p2_left, p2_right;
    logic       p1_fire, p2_fire;
    logic [7:0] scancode;
    logic       scancode_valid, frame_err;

    int checks   = 0;
    int failures = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;

    ps2_direction_decoder #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .TO_W           (16)
    ) dut (
        .Clock          (Clock),
        .rstn           (rstn),
        .PS2_CLK        (PS2_CLK),
        .PS2_DAT        (PS2_DAT),
        .p1_up          (p1_up),
        .p1_down        (p1_down),
        .p1_left        (p1_left),
        .p1_right       (p1_right),
        .p2_up          (p2_up),
        .p2_down        (p2_down),
        .p2_left        (p2_left),
        .p2_right       (p2_right),
        .p1_fire        (p1_fire),
        .p2_fire        (p2_fire),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .frame_err      (frame_err)
    );

    always #5 Clock = ~Clock;

    // Count strobe cycles; a stuck strobe shows up as an oversized count
    always @(negedge Clock) begin
        if (scancode_valid) valid_cnt++;
        if (frame_err)      err_cnt++;
    end

    // Flag order: p1 up,down,left,right,fire (bits 0-4), p2 up,down,left,right,fire (5-9)
    function automatic logic [9:0] flags();
        return {p2_fire, p2_right, p2_left, p2_down, p2_up,
                p1_fire, p1_right, p1_left, p1_down, p1_up};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DAT = b;
        repeat (HALF) @(posedge Clock);
        #1 PS2_CLK = 1'b0;
        repeat (HALF) @(posedge Clock);
        #1 PS2_CLK = 1'b1;
    endtask

    // Send the first nbits of a frame (11 = complete), then idle the lines
    task automatic send_frame(input logic [7:0] code, input logic flip_par,
                              input logic bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^code) ^ flip_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
        PS2_DAT = 1'b1;
    endtask

    typedef struct {
        logic [7:0] code;
        logic       flip_par;
        logic       bad_stop;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_sc;
        logic [9:0] exp_flags;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] c, input logic fp, input logic bs,
                                input int ev, input int ee, input logic [7:0] sc,
                                input logic [9:0] fl);
        vec_t v;
        v.code = c; v.flip_par = fp; v.bad_stop = bs;
        v.exp_valid = ev; v.exp_err = ee; v.exp_sc = sc; v.exp_flags = fl;
        return v;
    endfunction

    task automatic run_frame(input string tag, input vec_t v);
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(v.code, v.flip_par, v.bad_stop, 11);
        repeat (GAP) @(posedge Clock);
        @(negedge Clock);
        #1;
        check({tag, " valid_pulses"}, valid_cnt - v0, v.exp_valid);
        check({tag, " err_pulses"},   err_cnt - e0,   v.exp_err);
        check({tag, " scancode"},     scancode,       v.exp_sc);
        check({tag, " flags"},        flags(),        v.exp_flags);
        $display("frame %02h par_flip=%0b bad_stop=%0b -> sc=%02h flags=%03h",
                 v.code, v.flip_par, v.bad_stop, scancode, flags());
    endtask

    initial begin
        int v0, e0;

        // make/break of W, E0 arrows, ext/non-ext mismatches, bad frames clearing prefixes
        vecs.push_back(mk(8'h1D, 0, 0, 1, 0, 8'h1D, 10'h001));
        vecs.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 10'h001));
        vecs.push_back(mk(8'h1D, 0, 0, 1, 0, 8'h1D, 10'h000));
        vecs.push_back(mk(8'hE0, 0, 0, 1, 0, 8'hE0, 10'h000));
        vecs.push_back(mk(8'h75, 0, 0, 1, 0, 8'h75, 10'h020));
        vecs.push_back(mk(8'hE0, 0, 0, 1, 0, 8'hE0, 10'h020));
        vecs.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 10'h020));
        vecs.push_back(mk(8'h75, 0, 0, 1, 0, 8'h75, 10'h000));
        vecs.push_back(mk(8'h75, 0, 0, 1, 0, 8'h75, 10'h000));
        vecs.push_back(mk(8'h1C, 1, 0, 0, 1, 8'h75, 10'h000));
        vecs.push_back(mk(8'h1C, 0, 0, 1, 0, 8'h1C, 10'h004));
        vecs.push_back(mk(8'hE0, 0, 0, 1, 0, 8'hE0, 10'h004));
        vecs.push_back(mk(8'h1D, 0, 0, 1, 0, 8'h1D, 10'h004));
        vecs.push_back(mk(8'h1D, 0, 0, 1, 0, 8'h1D, 10'h005));
        vecs.push_back(mk(8'hE0, 0, 0, 1, 0, 8'hE0, 10'h005));
        vecs.push_back(mk(8'h00, 1, 0, 0, 1, 8'hE0, 10'h005));
        vecs.push_back(mk(8'h75, 0, 0, 1, 0, 8'h75, 10'h005));
        vecs.push_back(mk(8'h23, 0, 1, 0, 1, 8'h75, 10'h005));
        vecs.push_back(mk(8'h23, 0, 0, 1, 0, 8'h23, 10'h00D));
        vecs.push_back(mk(8'hE0, 0, 0, 1, 0, 8'hE0, 10'h00D));
        vecs.push_back(mk(8'h72, 0, 0, 1, 0, 8'h72, 10'h04D));
        vecs.push_back(mk(8'hE0, 0, 0, 1, 0, 8'hE0, 10'h04D));
        vecs.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 10'h04D));
        vecs.push_back(mk(8'h72, 0, 0, 1, 0, 8'h72, 10'h00D));
        vecs.push_back(mk(8'hE1, 0, 0, 1, 0, 8'hE1, 10'h00D));
        vecs.push_back(mk(8'h14, 0, 0, 1, 0, 8'h14, 10'h00D));
        vecs.push_back(mk(8'h1D, 0, 0, 1, 0, 8'h1D, 10'h00D));
        vecs.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 10'h00D));
        vecs.push_back(mk(8'h23, 0, 0, 1, 0, 8'h23, 10'h005));

        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        rstn    = 1'b0;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("reset flags",    flags(),        10'h000);
        check("reset scancode", scancode,       8'h00);
        check("reset valid",    scancode_valid, 1'b0);
        check("reset err",      frame_err,      1'b0);
        rstn = 1'b1;
        repeat (5) @(posedge Clock);

        for (int i = 0; i < vecs.size(); i++) run_frame($sformatf("vec%0d", i), vecs[i]);

        // Stalled frame: start + 4 data bits then silence past the timeout
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h23, 0, 0, 5);
        repeat (TIMEOUT + 60) @(posedge Clock);
        @(negedge Clock);
        check("timeout err_pulses",   err_cnt - e0,   1);
        check("timeout valid_pulses", valid_cnt - v0, 0);
        check("timeout scancode",     scancode,       8'h23);
        $display("timeout: err_pulses=%0d valid_pulses=%0d", err_cnt - e0, valid_cnt - v0);
        run_frame("after_timeout", mk(8'h23, 0, 0, 1, 0, 8'h23, 10'h00D));

        // Both fires held, then reset asserted mid-frame
        run_frame("fire1", mk(8'h29, 0, 0, 1, 0, 8'h29, 10'h01D));
        run_frame("fire2", mk(8'h5A, 0, 0, 1, 0, 8'h5A, 10'h21D));
        send_frame(8'h1D, 0, 0, 4);
        @(negedge Clock);
        #2 rstn = 1'b0;
        #1;
        check("async_reset flags",    flags(),        10'h000);
        check("async_reset scancode", scancode,       8'h00);
        check("async_reset valid",    scancode_valid, 1'b0);
        check("async_reset err",      frame_err,      1'b0);
        $display("async reset mid-frame: flags=%03h sc=%02h", flags(), scancode);
        repeat (3) @(posedge Clock);
        #1 rstn = 1'b1;
        repeat (5) @(posedge Clock);
        run_frame("post_reset", mk(8'h29, 0, 0, 1, 0, 8'h29, 10'h010));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_direction_decoder.md
Name: ps2_direction_decoder

Overview:
PS/2 keyboard receiver and scan-code decoder. It produces the held-key direction and fire flags for both players, which feed the up/down/left/right inputs of the sprite draw/move blocks. It takes the raw PS2_CLK/PS2_DAT pins, deserialises 11-bit frames and tracks set-2 make/break/extended sequences. The flags are level outputs that stay high while a key is held.

Parameters:
TIMEOUT_CYCLES, 50000, max Clock cycles between PS/2 falling edges inside a frame before the frame is aborted (1 ms at 50 MHz)
TO_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
Clock  input  1  system clock, 50 MHz
rstn  input  1  reset, asynchronous, active-low
PS2_CLK  input  1  raw keyboard clock, asynchronous to Clock
PS2_DAT  input  1  raw keyboard data, asynchronous to Clock
p1_up, p1_down, p1_left, p1_right  output  1 each  player 1 held flags (W, S, A, D)
p2_up, p2_down, p2_left, p2_right  output  1 each  player 2 held flags (arrow keys, E0-prefixed)
p1_fire, p2_fire  output  1 each  held flags (Space, Enter)
scancode  output  8  last correctly received byte
scancode_valid  output  1  one-cycle strobe when scancode is updated
frame_err  output  1  one-cycle strobe on parity, start, stop or timeout error

Behaviour:
- Reset (async, rstn=0): all key flags 0; scancode 8'h00; scancode_valid 0; frame_err 0; receive FSM in IDLE; ext and brk prefix flags 0; sync flops 1.
- Synchronisation: PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser. A registered previous-clock flop gives fe = prev & ~sync_clk. All sampling happens on cycles where fe=1.
- Receive FSM states:
  - IDLE: on fe with dat=0 (start bit) go to DATA, bitcnt=0. On fe with dat=1, stay in IDLE and pulse frame_err.
  - DATA: on fe shift dat in LSB first. After the 8th bit go to PARITY.
  - PARITY: on fe capture the parity bit, go to STOP.
  - STOP: on fe, if dat=1 and (^data ^ parity)=1 (odd parity), load scancode and pulse scancode_valid on the next cycle. Otherwise pulse frame_err. Return to IDLE in both cases.
- Timeout: counter clears on every fe and increments each cycle while not in IDLE. When it reaches TIMEOUT_CYCLES the FSM returns to IDLE, frame_err pulses for one cycle, and partial data is discarded.
- Decode stage, acting in the cycle where scancode_valid=1 (flags visible the following cycle):
  - 8'hE0: set ext.
  - 8'hF0: set brk.
  - Any other byte: look up (ext, byte). On a match, write the flag with ~brk (make=1, break=0). Then clear ext and brk whether or not the byte matched.
- Key map:
  - ext=0: 1D p1_up, 1B p1_down, 1C p1_left, 23 p1_right, 29 p1_fire, 5A p2_fire.
  - ext=1: 75 p2_up, 72 p2_down, 6B p2_left, 74 p2_right.
  - ext=1 with a non-extended code, or ext=0 with an arrow code: no flag change.
- Typematic repeats (repeated make codes) leave a flag at 1; they are idempotent.
- frame_err also clears ext and brk, so a half-received prefix never corrupts the next key.
- Opposing directions held together (e.g. p1_left and p1_right) are both output as 1. Arbitration belongs to the consumer.
- E1 (Pause) sequences decode only as unmapped bytes; no flag changes.
- Reset mid-frame aborts the frame immediately; the first edge after release must be a start bit.
- No transmit to the keyboard: PS2_CLK and PS2_DAT are never driven.

Decomposition:
- Shared package holds the scan-code constants (SC_W, SC_A, SC_S, SC_D, SC_SPACE, SC_ENTER, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, SC_EXT=E0, SC_BRK=F0) and the receive-state encodings.
- One sub-module, ps2_rx_frame, contains the synchronisers, edge detect, frame FSM and timeout. It outputs scancode, scancode_valid and frame_err.
- The top level adds the prefix tracker and the key-flag registers.

Test Plan:
- Frame 1D with correct parity (P=1) -> scancode=8'h1D, one scancode_valid pulse, p1_up=1 next cycle; all other flags 0.
- Then F0, 1D -> p1_up=0 after the second byte; no frame_err.
- E0,75 then E0,F0,75 -> p2_up rises after the first sequence, falls after the second. Plain 75 alone -> no flag changes.
- Frame 1C with parity bit flipped -> frame_err pulse, scancode keeps its old value, p1_left stays 0. Next good 1C -> p1_left=1.
- Start bit plus 4 data bits, then idle for TIMEOUT_CYCLES -> frame_err pulse and FSM back in IDLE. Next full frame 23 -> p1_right=1.
- Hold 29 and 5A (both fires = 1), then pulse rstn low mid-frame -> all outputs 0 asynchronously. Frames after release decode normally.
